seq_shifter: RTL and testbench
==============================

// Module: seq_shifter
// PURPOSE
//  Multi-cycle logical shift unit: accepts operand a, shift amount b and op over a valid/ready
//  handshake, shifts STEP bits per cycle, and returns the result over a second valid/ready port.
//  Area-lean sequential alternative to the single-cycle ALU shifter. Sits beside the ALU and is
//  driven by the execute-stage issue logic.
// PARAMETERS
//  WIDTH    32               operand/result width
//  SHAMT_W  $clog2(WIDTH)    shift-amount width (5 at default)
//  STEP     1                bits shifted per busy cycle; power of two, 1..WIDTH
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        request valid
//  in_ready   out  1        unit can accept request (IDLE only)
//  a          in   WIDTH    operand
//  b          in   SHAMT_W  shift amount, 0..WIDTH-1
//  op         in   2        00 SLL, 01 SRL, 1x SRA (see CONFIGURATION)
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  result     out  WIDTH    shifted value; held stable while out_valid && !out_ready
//  busy       out  1        high in SHIFT or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, acc=0, cnt=0.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid: acc<=a, cnt<=b, op latched; next = (b==0) ? DONE : SHIFT.
//    SHIFT: each cycle acc <= acc shifted by k=min(STEP,cnt), cnt<=cnt-k; next DONE when cnt-k==0.
//    DONE: out_valid=1, result=acc; on out_ready -> IDLE (no accept in that same cycle).
//  - Latency: out_valid rises 1+ceil(b/STEP) cycles after the accepting edge; b=0 -> 1 cycle.
//  - SLL/SRL zero-fill; shifted-out bits discarded; no overflow flag.
//  - in_ready=0 outside IDLE; in_valid there is ignored, inputs not sampled.
//  - Backpressure: DONE holds indefinitely; result/out_valid bit-stable until out_ready.
//  - Reset mid-operation: next cycle all outputs at reset values; in-flight request dropped.
//  - rst dominates any simultaneous in_valid/out_ready.
// CONFIGURATION
//  SEQ_SHIFTER_SRA_EN defined: op=1x performs arithmetic right shift (fill with sign bit a[WIDTH-1]
//    latched at accept).
//  Undefined: op[1] ignored; 1x decodes as op[0] (10 -> SLL, 11 -> SRL); no sign logic built.
// STRUCTURE
//  - seq_shifter_pkg: op encoding localparams (OP_SLL, OP_SRL, OP_SRA), FSM state enum.
//  - Sub-module shift_step: combinational acc x k x op -> next acc (k <= STEP); one instance.
//  - Top holds FSM, acc/cnt/op registers and handshake logic.
// TESTING (WIDTH=32, STEP=1 unless stated)
//  - a=12345678,b=0,op=SLL -> result 12345678, out_valid 1 cycle after accept.
//  - a=12345678,b=1,op=SRL -> 091A2B3C, out_valid 2 cycles after accept; a=80000001,SLL,b=1 -> 00000002.
//  - a=00000001,b=31,op=SLL -> 80000000 exactly 32 cycles after accept; in_ready=0 and busy=1 throughout;
//    repeat with STEP=4 -> 9 cycles.
//  - Backpressure: a=FFFFFFFF,b=16,SRL, out_ready low 5 cycles in DONE -> 0000FFFF stable;
//    in_valid pulses during DONE ignored.
//  - Reset mid-shift: b=16, rst at 5th SHIFT cycle -> next cycle out_valid=0, in_ready=1, result=0;
//    following request a=AAAAAAAA,b=31,SRL -> 00000001.
//  - SRA: a=80000000,b=31,op=10 -> FFFFFFFF with SEQ_SHIFTER_SRA_EN; without it -> 00000000 (SLL).

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: op encodings and FSM states.
package seq_shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One combinational shift step: acc shifted by k (k <= STEP) in the direction given by op.
// Build option SEQ_SHIFTER_SRA_EN adds the arithmetic-right path filled with the latched sign.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned KW    = 6
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
`ifdef SEQ_SHIFTER_SRA_EN
  input  logic             sign,
`endif
  output logic [WIDTH-1:0] acc_next
);

`ifdef SEQ_SHIFTER_SRA_EN
  logic [WIDTH-1:0] fill_mask;

  // Top k bits set; these receive the sign bit on an arithmetic shift.
  always_comb begin
    fill_mask = ~({WIDTH{1'b1}} >> k);
  end

  // Select the shift flavour; op[1] overrides the direction bit.
  always_comb begin
    acc_next = acc;
    if (op[1]) begin
      acc_next = (acc >> k) | (fill_mask & {WIDTH{sign}});
    end else if (op == OP_SRL) begin
      acc_next = acc >> k;
    end else begin
      acc_next = acc << k;
    end
  end
`else
  // Without the arithmetic path only the direction bit matters.
  logic unused_op_hi;
  assign unused_op_hi = op[1];

  // Logical shift, zero fill in both directions.
  always_comb begin
    acc_next = acc;
    if (op[0]) begin
      acc_next = acc >> k;
    end else begin
      acc_next = acc << k;
    end
  end
`endif

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle logical shift unit with valid/ready request and result ports.
// Shifts STEP bits per busy cycle. Define SEQ_SHIFTER_SRA_EN to make op=1x an arithmetic
// right shift; otherwise op[1] is ignored.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  // One extra bit so STEP == WIDTH is representable as a step amount.
  localparam int unsigned  KW     = SHAMT_W + 1;
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [1:0]         op_q;
`ifdef SEQ_SHIFTER_SRA_EN
  logic               sign_q;
`endif

  logic [KW-1:0]    cnt_ext;
  logic [KW-1:0]    k;
  logic [KW-1:0]    cnt_rem;
  logic [WIDTH-1:0] acc_next;

  // Step size is the remaining count, capped at STEP.
  always_comb begin
    cnt_ext = {1'b0, cnt_q};
    k       = (cnt_ext >= STEP_K) ? STEP_K : cnt_ext;
    cnt_rem = cnt_ext - k;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_shift_step (
    .acc      (acc_q),
    .k        (k),
    .op       (op_q),
`ifdef SEQ_SHIFTER_SRA_EN
    .sign     (sign_q),
`endif
    .acc_next (acc_next)
  );

  // FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= OP_SLL;
`ifdef SEQ_SHIFTER_SRA_EN
      sign_q    <= 1'b0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            acc_q    <= a;
            cnt_q    <= b;
`ifdef SEQ_SHIFTER_SRA_EN
            op_q     <= op;
            sign_q   <= a[WIDTH-1];
`else
            op_q     <= {1'b0, op[0]};
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (b == '0) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              result    <= a;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          acc_q <= acc_next;
          cnt_q <= cnt_rem[SHAMT_W-1:0];
          if (cnt_rem == '0) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            result    <= acc_next;
          end
        end
        StDone: begin
          // Result stays put until the consumer takes it; no new accept this cycle.
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter (WIDTH=32, STEP=1) plus a STEP=4 latency check.
module tb_seq_shifter;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, result;
  logic [4:0]  b;
  logic [1:0]  op;

  logic        s4_in_valid, s4_in_ready, s4_out_valid, s4_busy;
  logic [31:0] s4_a, s4_result;
  logic [4:0]  s4_b;
  logic [1:0]  s4_op;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc_cyc;
    int          id;
  } exp_t;
  exp_t sb[$];

  logic        seen = 1'b0;
  logic [31:0] held;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s4_in_valid),
    .in_ready  (s4_in_ready),
    .a         (s4_a),
    .b         (s4_b),
    .op        (s4_op),
    .out_valid (s4_out_valid),
    .out_ready (1'b1),
    .result    (s4_result),
    .busy      (s4_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: latency on first out_valid, stability while held, value on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          if (!seen) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %h, expected no output", result);
          end
          seen = !out_ready;
        end else begin
          if (!seen) begin
            seen = 1'b1;
            held = result;
            check($sformatf("latency#%0d", sb[0].id), 32'(cyc - sb[0].acc_cyc),
                  32'(sb[0].lat));
          end else begin
            check($sformatf("hold#%0d", sb[0].id), result, held);
          end
          if (out_ready) begin
            check($sformatf("result#%0d", sb[0].id), result, sb[0].data);
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int id, input logic [31:0] ta, input logic [4:0] tb_,
                       input logic [1:0] top, input logic [31:0] exp, input int lat);
    exp_t e;
    int   g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout#%0d: in_ready %b, expected 1", id, in_ready);
    end else begin
      a        = ta;
      b        = tb_;
      op       = top;
      in_valid = 1'b1;
      e.data    = exp;
      e.lat     = lat;
      e.acc_cyc = cyc;
      e.id      = id;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int id);
    int g = 0;
    while ((sb.size() != 0 || !in_ready) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    tests++;
    if (sb.size() != 0 || !in_ready) begin
      fails++;
      $display("FAIL done_timeout#%0d: pending %0d, expected 0", id, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int g;
    int start;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = SLL;
    s4_in_valid = 1'b0; s4_a = '0; s4_b = '0; s4_op = SLL;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1, 32'h12345678, 5'd0, SLL, 32'h12345678, 1);
    wait_done(1);
    issue(2, 32'h12345678, 5'd1, SRL, 32'h091A2B3C, 2);
    wait_done(2);
    issue(3, 32'h80000001, 5'd1, SLL, 32'h00000002, 2);
    wait_done(3);

    // Long shift: busy and not ready through every SHIFT cycle.
    issue(4, 32'h00000001, 5'd31, SLL, 32'h80000000, 32);
    for (int i = 0; i < 31; i++) begin
      check($sformatf("busy_c%0d", i), {29'd0, busy, in_ready, out_valid}, 32'b100);
      @(posedge clk);
      #1;
    end
    wait_done(4);

    // Backpressure with ignored in_valid pulses during DONE.
    out_ready = 1'b0;
    issue(5, 32'hFFFFFFFF, 5'd16, SRL, 32'h0000FFFF, 17);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      in_valid = (i % 2 == 0);
      a = 32'h0; b = 5'd0; op = SLL;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done(5);

    // Reset during the 5th SHIFT cycle drops the request.
    issue(6, 32'h12345678, 5'd16, SLL, 32'h0, 17);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    issue(7, 32'hAAAAAAAA, 5'd31, SRL, 32'h00000001, 32);
    wait_done(7);

`ifdef SEQ_SHIFTER_SRA_EN
    issue(8, 32'h80000000, 5'd31, SRA, 32'hFFFFFFFF, 32);
`else
    issue(8, 32'h80000000, 5'd31, SRA, 32'h00000000, 32);
`endif
    wait_done(8);

    // STEP=4 instance: 1 + ceil(31/4) = 9 cycles.
    s4_a = 32'h00000001; s4_b = 5'd31; s4_op = SLL; s4_in_valid = 1'b1;
    start = cyc;
    @(posedge clk);
    #1;
    s4_in_valid = 1'b0;
    g = 0;
    while (!s4_out_valid && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("step4_latency", 32'(cyc - start), 32'd9);
    check("step4_result", s4_result, 32'h80000000);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
